// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT configuration sequencer.
// LUT_CFG_CHECK_EN adds a per-LUT checksum byte and the CHK state.
package lut_cfg_pkg;

  localparam int unsigned LUT_BITS = 16;

`ifdef LUT_CFG_CHECK_EN
  localparam int unsigned CFG_BYTES_PER_LUT = 3;
`else
  localparam int unsigned CFG_BYTES_PER_LUT = 2;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
`ifdef LUT_CFG_CHECK_EN
    StChk,
`endif
    StWrite,
    StDone
  } lut_cfg_state_e;

endpackage

// File: rtl/lut_cfg_ctrl_if.sv
// Control, configuration-stream and LUT-bank signals of lut_cfg_ctrl.
// Signal suffixes are from the controller's point of view (slave modport).
interface lut_cfg_ctrl_if #(
  parameter int unsigned NUM_LUTS = 8
);
  import lut_cfg_pkg::*;

  logic                start_i;
  logic                abort_i;
  logic                cfg_valid_i;
  logic [7:0]          cfg_data_i;
  logic                cfg_ready_o;
  logic [LUT_BITS-1:0] lut_data_o;
  logic [NUM_LUTS-1:0] lut_we_o;
  logic                busy_o;
  logic                done_o;
  logic                err_o;

  modport slave (
    input  start_i, abort_i, cfg_valid_i, cfg_data_i,
    output cfg_ready_o, lut_data_o, lut_we_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, abort_i, cfg_valid_i, cfg_data_i,
    input  cfg_ready_o, lut_data_o, lut_we_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/lut_cfg_asm.sv
// Byte-to-word assembler: holds the truth table being built and, with
// LUT_CFG_CHECK_EN, compares the incoming byte against lo^hi.
module lut_cfg_asm
  import lut_cfg_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                lo_en_i,
  input  logic                hi_en_i,
  input  logic [7:0]          byte_i,
`ifdef LUT_CFG_CHECK_EN
  output logic                chk_ok_o,
`endif
  output logic [LUT_BITS-1:0] word_o
);

  logic [LUT_BITS-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (lo_en_i) data_d[7:0]  = byte_i;
    if (hi_en_i) data_d[15:8] = byte_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Next-state view so the top can register the word in the same edge as the HI capture.
  assign word_o = data_d;

`ifdef LUT_CFG_CHECK_EN
  assign chk_ok_o = (byte_i == (data_q[7:0] ^ data_q[15:8]));
`endif

endmodule

// File: rtl/lut_cfg_ctrl.sv
// Configuration sequencer: assembles 16-bit truth tables from a byte stream and
// strobes each LUT in ascending order. LUT_CFG_CHECK_EN enables per-LUT checksums.
module lut_cfg_ctrl
  import lut_cfg_pkg::*;
#(
  parameter int unsigned NUM_LUTS = 8
) (
  input logic           clk_i,
  input logic           reset_i,
  lut_cfg_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LUTS - 1);

  lut_cfg_state_e      state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                cfg_ready_q, busy_q, done_q;
  logic [NUM_LUTS-1:0] we_q, we_d;
  logic [LUT_BITS-1:0] data_q, word;
  logic                xfer, last, lo_en, hi_en;
`ifdef LUT_CFG_CHECK_EN
  logic                err_q, err_d, chk_ok;
`endif

  assign xfer = bus.cfg_valid_i & cfg_ready_q;
  assign last = (idx_q == LastIdx);

  lut_cfg_asm u_asm (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .lo_en_i  (lo_en),
    .hi_en_i  (hi_en),
    .byte_i   (bus.cfg_data_i),
`ifdef LUT_CFG_CHECK_EN
    .chk_ok_o (chk_ok),
`endif
    .word_o   (word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_en   = 1'b0;
    hi_en   = 1'b0;
`ifdef LUT_CFG_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StLo;
          idx_d   = '0;
`ifdef LUT_CFG_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      StLo: begin
        if (bus.abort_i) begin
          state_d = StIdle;
        end else if (xfer) begin
          lo_en   = 1'b1;
          state_d = StHi;
        end
      end
      StHi: begin
        if (bus.abort_i) begin
          state_d = StIdle;
        end else if (xfer) begin
          hi_en   = 1'b1;
`ifdef LUT_CFG_CHECK_EN
          state_d = StChk;
`else
          state_d = StWrite;
`endif
        end
      end
`ifdef LUT_CFG_CHECK_EN
      StChk: begin
        if (bus.abort_i) begin
          state_d = StIdle;
        end else if (xfer) begin
          if (chk_ok) begin
            state_d = StWrite;
          end else begin
            // Bad checksum: drop this LUT and carry on with the pass.
            err_d = 1'b1;
            if (last) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StLo;
            end
          end
        end
      end
`endif
      StWrite: begin
        if (bus.abort_i) begin
          state_d = StIdle;
        end else if (last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StLo;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d = '0;
    if (state_d == StWrite) we_d[idx_q] = 1'b1;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_ready_q <= (state_d == StLo) || (state_d == StHi)
`ifdef LUT_CFG_CHECK_EN
                     || (state_d == StChk)
`endif
                     ;
      busy_q      <= (state_d != StIdle) && (state_d != StDone);
      done_q      <= (state_d == StDone);
      we_q        <= we_d;
      if (state_d == StWrite) data_q <= word;
    end
  end

`ifdef LUT_CFG_CHECK_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.cfg_ready_o = cfg_ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.lut_we_o    = we_q;
  assign bus.lut_data_o  = data_q;

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Self-checking bench for lut_cfg_ctrl (NUM_LUTS=4); honours LUT_CFG_CHECK_EN.
module tb_lut_cfg_ctrl;
  import lut_cfg_pkg::*;

  localparam int unsigned N = 4;
  localparam int Per = CFG_BYTES_PER_LUT + 1;

  typedef struct {
    time         t;
    logic [3:0]  we;
    logic [15:0] data;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [3:0]  we;
    logic [15:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lut_cfg_ctrl_if #(.NUM_LUTS(N)) bus ();

  lut_cfg_ctrl #(.NUM_LUTS(N)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte source: random valid gaps controlled by src_duty (percent).
  logic [7:0] src_q[$];
  bit         src_en   = 1'b0;
  int         src_duty = 100;
  bit         xfer_pend = 1'b0;

  initial begin
    bus.cfg_valid_i = 1'b0;
    bus.cfg_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (xfer_pend && src_q.size() > 0) void'(src_q.pop_front());
      if (src_en && src_q.size() > 0 && int'($urandom_range(99)) < src_duty) begin
        bus.cfg_valid_i = 1'b1;
        bus.cfg_data_i  = src_q[0];
      end else begin
        bus.cfg_valid_i = 1'b0;
        bus.cfg_data_i  = 8'($urandom);
      end
      xfer_pend = bus.cfg_valid_i && bus.cfg_ready_o;
    end
  end

  // Strobe / done monitor.
  strobe_t log_q[$];
  time     done_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.lut_we_o != '0) begin
        log_q.push_back('{$time, bus.lut_we_o, bus.lut_data_o});
        chk("we_onehot", $countones(bus.lut_we_o), 1);
        chk("ready_in_write", {31'b0, bus.cfg_ready_o}, 0);
      end
      if (!reset && bus.done_o) begin
        done_q.push_back($time);
        chk("busy_at_done", {31'b0, bus.busy_o}, 0);
      end
    end
  end

  // Reference model: LUT i receives {hi,lo}; with checking, only if chk == lo^hi.
  strobe_t exp_q[$];
  bit      exp_err;

  function automatic logic [7:0] good_chk(input logic [15:0] w);
    return w[7:0] ^ w[15:8];
  endfunction

  task automatic prep(input logic [15:0] w[N], input logic [7:0] c[N]);
    bit ok;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      src_q.push_back(w[i][7:0]);
      src_q.push_back(w[i][15:8]);
      ok = 1'b1;
`ifdef LUT_CFG_CHECK_EN
      src_q.push_back(c[i]);
      ok = (c[i] == good_chk(w[i]));
`endif
      if (ok) exp_q.push_back('{0, 4'(1 << i), w[i]});
      else exp_err = 1'b1;
    end
  endtask

  task automatic start_pass(output time t0);
    #1;
    log_q.delete();
    done_q.delete();
    src_en = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1;
    t0 = $time;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (bus.done_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", {31'b0, got}, 1);
    #1;
  endtask

  task automatic src_flush();
    #1 src_en = 1'b0;
    @(negedge clk);
    #1 src_q.delete();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_we"}, {28'b0, log_q[i].we}, {28'b0, exp_q[i].we});
      chk({tag, "_data"}, {16'b0, log_q[i].data}, {16'b0, exp_q[i].data});
    end
    chk({tag, "_done_count"}, done_q.size(), 1);
    chk({tag, "_err"}, {31'b0, bus.err_o}, {31'b0, exp_err});
  endtask

  logic [15:0] words[N];
  logic [7:0]  chks[N];
  vec_t        tbl[N];
  time         t0;

  initial begin
    words = '{16'h1234, 16'hABCD, 16'hFF00, 16'hAA55};
    for (int i = 0; i < int'(N); i++) chks[i] = good_chk(words[i]);
    for (int i = 0; i < int'(N); i++) tbl[i] = '{Per * (i + 1), 4'(1 << i), words[i]};

    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bus.cfg_ready_o}, 0);
    chk("rst_data", {16'b0, bus.lut_data_o}, 0);
    chk("rst_we", {28'b0, bus.lut_we_o}, 0);
    chk("rst_busy", {31'b0, bus.busy_o}, 0);
    chk("rst_done", {31'b0, bus.done_o}, 0);
    chk("rst_err", {31'b0, bus.err_o}, 0);
    reset = 1'b0;

    // Directed stream, continuous valid, cycle-exact.
    prep(words, chks);
    start_pass(t0);
    wait_done(200);
    chk("t1_count", log_q.size(), N);
    for (int i = 0; i < int'(N) && i < log_q.size(); i++) begin
      chk("t1_cyc", int'((log_q[i].t - t0) / 10), tbl[i].cyc);
      chk("t1_we", {28'b0, log_q[i].we}, {28'b0, tbl[i].we});
      chk("t1_data", {16'b0, log_q[i].data}, {16'b0, tbl[i].data});
    end
    chk("t1_done_cyc", (done_q.size() > 0) ? int'((done_q[0] - t0) / 10) : -1, N * Per + 1);
    check_log("t1");
    @(negedge clk);
    chk("t1_busy_after", {31'b0, bus.busy_o}, 0);
    chk("t1_data_hold", {16'b0, bus.lut_data_o}, 32'hAA55);

    // Same words with 50% valid duty.
    src_duty = 50;
    prep(words, chks);
    start_pass(t0);
    wait_done(600);
    check_log("t2");

    // Random words and gaps; with checking, some bad checksums.
    for (int p = 0; p < 3; p++) begin
      logic [15:0] rw[N];
      logic [7:0]  rc[N];
      for (int i = 0; i < int'(N); i++) begin
        rw[i] = 16'($urandom);
        rc[i] = good_chk(rw[i]);
        if ($urandom_range(3) == 0) rc[i] = rc[i] ^ 8'h5A;
      end
      prep(rw, rc);
      start_pass(t0);
      wait_done(600);
      check_log("rnd");
    end
    src_duty = 100;

    // Abort during HI of LUT 2, then a fresh pass from LUT 0.
    prep(words, chks);
    start_pass(t0);
    repeat (2 * Per + 1) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("t3_busy", {31'b0, bus.busy_o}, 0);
    chk("t3_ready", {31'b0, bus.cfg_ready_o}, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("t3_strobes", log_q.size(), 2);
    chk("t3_done", done_q.size(), 0);
    src_flush();
    prep(words, chks);
    start_pass(t0);
    wait_done(200);
    check_log("t3_restart");

    // Asynchronous reset in the middle of the first WRITE cycle.
    prep(words, chks);
    start_pass(t0);
    repeat (Per - 1) @(negedge clk);
    chk("t4_we_before", {28'b0, bus.lut_we_o}, 1);
    reset = 1'b1;
    #1;
    chk("t4_we", {28'b0, bus.lut_we_o}, 0);
    chk("t4_data", {16'b0, bus.lut_data_o}, 0);
    chk("t4_busy", {31'b0, bus.busy_o}, 0);
    chk("t4_ready", {31'b0, bus.cfg_ready_o}, 0);
    chk("t4_done", {31'b0, bus.done_o}, 0);
    @(negedge clk);
    reset = 1'b0;
    src_flush();

`ifdef LUT_CFG_CHECK_EN
    // LUT 1 checksum 0x00 instead of 0x66.
    begin
      logic [7:0] bc[N];
      bc = chks;
      bc[1] = 8'h00;
      prep(words, bc);
      start_pass(t0);
      wait_done(200);
      check_log("t5");
      prep(words, chks);
      start_pass(t0);
      chk("t5_err_clear", {31'b0, bus.err_o}, 0);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      src_flush();
    end
`endif

    // start_i held through the pass: released (v=0) or kept one more cycle (v=1).
    for (int v = 0; v < 2; v++) begin
      prep(words, chks);
      #1;
      log_q.delete();
      done_q.delete();
      src_en = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b1;
      wait_done(200);
      @(negedge clk);
      bus.start_i = 1'(v);
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("t6_busy", {31'b0, bus.busy_o}, v);
      #1;
      if (v == 0) begin
        check_log("t6");
      end else begin
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
      end
      src_flush();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
